// File: rtl/div_pkg.sv
// Shared definitions for the HI/LO divide controller: FSM state encoding,
// the latched-operand record and the divider latency used by benches.
package div_pkg;

    localparam int XLEN = 32;

    // Cycles from the divider sampling its start strobe to its complete pulse.
    // The controller never counts this; it is exported for models and benches.
    localparam int DIV_LATENCY = 34;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RECOVER = 3'd3,
        ST_DISCARD = 3'd4
    } div_state_e;

    typedef struct packed {
        logic            sgn;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } div_op_t;

endpackage

// File: rtl/div_ctrl.sv
// Divide controller: latches a request, strobes the external iterative divider
// and captures quotient/remainder into LO/HI. Optional pipeline cancel: DIV_FLUSH_EN.
module div_ctrl
    import div_pkg::*;
(
    input  logic            div_clk,
    input  logic            resetn,
    input  logic            req_valid,
    input  logic            req_signed,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            req_ready,
    output logic            busy,
    input  logic            flush,
    input  logic            mthi_we,
    input  logic            mtlo_we,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            div,
    output logic            div_signed,
    output logic [XLEN-1:0] x,
    output logic [XLEN-1:0] y,
    input  logic [XLEN-1:0] s,
    input  logic [XLEN-1:0] r,
    input  logic            complete
);

    div_state_e      state_q, state_d;
    div_op_t         op_q, op_d;
    logic            busy_q, busy_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            flush_act;

`ifdef DIV_FLUSH_EN
    assign flush_act = flush;
`else
    logic flush_unused;
    assign flush_unused = flush;
    assign flush_act    = 1'b0;
`endif

    always_comb begin
        // NOTE: every combinational target gets a default first so no path infers a latch.
        state_d = state_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        // Direct moves first; a same-edge result capture below overrides them.
        if (mthi_we) hi_d = wdata;
        if (mtlo_we) lo_d = wdata;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = '{sgn: req_signed, a: req_a, b: req_b};
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = flush_act ? ST_DISCARD : ST_WAIT;
            end
            ST_WAIT: begin
                if (complete) begin
                    state_d = ST_RECOVER;
                    if (!flush_act) begin
                        lo_d = s;
                        hi_d = r;
                    end
                end else if (flush_act) begin
                    state_d = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (complete) state_d = ST_RECOVER;
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge div_clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = busy_q;
    assign div        = (state_q == ST_LAUNCH);
    assign div_signed = op_q.sgn;
    assign x          = op_q.a;
    assign y          = op_q.b;
    assign hi         = hi_q;
    assign lo         = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural 34-cycle divider model;
// flush expectations follow the DIV_FLUSH_EN build setting.
module tb_div_ctrl;
    import div_pkg::*;

    logic        div_clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_signed;
    logic [31:0] req_a, req_b;
    logic        req_ready, busy, flush;
    logic        mthi_we, mtlo_we;
    logic [31:0] wdata, hi, lo;
    logic        div, div_signed;
    logic [31:0] x, y, s, r;
    logic        complete;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0, acc_total = 0, acc_last = 0, acc_prev = 0, div_pulses = 0;
    logic [31:0] m_hi = 32'h0, m_lo = 32'h0;

    always #5 div_clk = ~div_clk;

    div_ctrl dut (
        .div_clk(div_clk), .resetn(resetn),
        .req_valid(req_valid), .req_signed(req_signed), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .busy(busy), .flush(flush),
        .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata),
        .hi(hi), .lo(lo), .div(div), .div_signed(div_signed),
        .x(x), .y(y), .s(s), .r(r), .complete(complete)
    );

    // Behavioural divider: samples operands on the start strobe, pulses complete
    // DIV_LATENCY cycles later; s/r carry garbage outside the complete cycle.
    logic [5:0]  m_cnt;
    logic [31:0] m_q, m_r;
    always @(posedge div_clk) begin
        if (!resetn) begin
            m_cnt    <= '0;
            complete <= 1'b0;
            s        <= '0;
            r        <= '0;
        end else begin
            complete <= 1'b0;
            s        <= 32'hDEAD_BEEF;
            r        <= 32'hDEAD_BEEF;
            if (div) begin
                m_cnt <= 6'(DIV_LATENCY);
                if (y == 32'h0) begin
                    m_q <= 32'hFFFF_FFFF;
                    m_r <= x;
                end else if (div_signed) begin
                    m_q <= $signed(x) / $signed(y);
                    m_r <= $signed(x) % $signed(y);
                end else begin
                    m_q <= x / y;
                    m_r <= x % y;
                end
            end else if (m_cnt != 6'd0) begin
                m_cnt <= m_cnt - 6'd1;
                if (m_cnt == 6'd1) begin
                    complete <= 1'b1;
                    s        <= m_q;
                    r        <= m_r;
                end
            end
        end
    end

    always @(posedge div_clk) begin
        cyc = cyc + 1;
        if (div) div_pulses = div_pulses + 1;
        if (resetn && req_valid && req_ready) begin
            acc_total = acc_total + 1;
            acc_prev  = acc_last;
            acc_last  = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Presents a request at a negedge; returns at the negedge after the accept edge.
    task automatic start_op(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        req_valid  = 1'b1;
        req_signed = sgn;
        req_a      = a;
        req_b      = b;
        for (int n = 0; n < 64 && !req_ready; n++) @(negedge div_clk);
        check({tag, "_ready"}, req_ready, 1);
        @(negedge div_clk);
        req_valid = 1'b0;
    endtask

    // Full operation with cycle-exact checks: update lands 36 edges after accept.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        start_op(tag, sgn, a, b);
        check({tag, "_div_launch"}, div, 1);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_x"}, x, a);
        check({tag, "_y"}, y, b);
        check({tag, "_sgn"}, div_signed, sgn);
        @(negedge div_clk);
        check({tag, "_div_wait"}, div, 0);
        repeat (34) @(negedge div_clk);
        check({tag, "_lo_before"}, lo, m_lo);
        @(negedge div_clk);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_busy_recover"}, busy, 1);
        @(negedge div_clk);
        check({tag, "_busy_idle"}, busy, 0);
        check({tag, "_ready_idle"}, req_ready, 1);
        m_lo = exp_lo;
        m_hi = exp_hi;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_acc, base_pulses;
        resetn = 1'b0; req_valid = 1'b0; req_signed = 1'b0; req_a = '0; req_b = '0;
        flush = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0; wdata = '0;
        repeat (3) @(negedge div_clk);
        check("rst_busy", busy, 0);
        check("rst_div", div, 0);
        check("rst_div_signed", div_signed, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_ready", req_ready, 1);

        // First request presented together with reset release.
        resetn = 1'b1;
        run_op("div_7_2", 1'b1, 32'd7, 32'd2, 32'd3, 32'd1);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op("divu_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1);
        run_op("div_by_0", 1'b1, 32'd123, 32'd0, 32'hFFFF_FFFF, 32'd123);

        // Direct LO write in IDLE.
        mtlo_we = 1'b1; wdata = 32'h1234;
        @(negedge div_clk);
        mtlo_we = 1'b0;
        check("mtlo_idle_lo", lo, 32'h1234);
        check("mtlo_idle_hi", hi, 32'd123);

        // HI write mid-WAIT, then HI/LO writes colliding with result capture.
        start_op("mtx", 1'b1, 32'd9, 32'd2);
        repeat (10) @(negedge div_clk);
        mthi_we = 1'b1; wdata = 32'h77;
        @(negedge div_clk);
        mthi_we = 1'b0;
        check("mthi_wait_hi", hi, 32'h77);
        check("mthi_wait_busy", busy, 1);
        repeat (24) @(negedge div_clk);
        mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'h5555;
        @(negedge div_clk);
        mthi_we = 1'b0; mtlo_we = 1'b0;
        check("collide_lo", lo, 32'd4);
        check("collide_hi", hi, 32'd1);
        @(negedge div_clk);
        check("collide_busy", busy, 0);
        m_lo = 32'd4; m_hi = 32'd1;

        // Back-to-back with req_valid held high throughout.
        base_acc = acc_total;
        base_pulses = div_pulses;
        req_valid = 1'b1; req_signed = 1'b1; req_a = 32'd100; req_b = 32'd7;
        for (int n = 0; n < 64 && acc_total == base_acc; n++) @(negedge div_clk);
        req_a = 32'd9; req_b = 32'd3;
        @(negedge div_clk);
        check("b2b_x_held", x, 32'd100);
        check("b2b_y_held", y, 32'd7);
        for (int n = 0; n < 80 && acc_total < base_acc + 2; n++) @(negedge div_clk);
        req_valid = 1'b0;
        check("b2b_accepts", acc_total - base_acc, 2);
        check("b2b_gap_ge_37", (acc_last - acc_prev) >= 37, 1);
        check("b2b_first_lo", lo, 32'd14);
        check("b2b_first_hi", hi, 32'd2);
        for (int n = 0; n < 64 && busy; n++) @(negedge div_clk);
        check("b2b_busy_done", busy, 0);
        check("b2b_lo", lo, 32'd3);
        check("b2b_hi", hi, 32'd0);
        check("b2b_div_pulses", div_pulses - base_pulses, 2);
        m_lo = 32'd3; m_hi = 32'd0;

        // Flush 10 cycles after accepting 50/5 with HI/LO preloaded.
        mthi_we = 1'b1; wdata = 32'hAA;
        @(negedge div_clk);
        mthi_we = 1'b0; mtlo_we = 1'b1; wdata = 32'hBB;
        @(negedge div_clk);
        mtlo_we = 1'b0;
        start_op("flush", 1'b1, 32'd50, 32'd5);
        repeat (10) @(negedge div_clk);
        flush = 1'b1;
        @(negedge div_clk);
        flush = 1'b0;
        repeat (24) @(negedge div_clk);
        @(negedge div_clk);
`ifdef DIV_FLUSH_EN
        check("flush_hi", hi, 32'hAA);
        check("flush_lo", lo, 32'hBB);
        m_lo = 32'hBB; m_hi = 32'hAA;
`else
        check("noflush_hi", hi, 32'd0);
        check("noflush_lo", lo, 32'd10);
        m_lo = 32'd10; m_hi = 32'd0;
`endif
        check("flush_busy_recover", busy, 1);
        @(negedge div_clk);
        check("flush_busy_idle", busy, 0);
        run_op("after_flush_8_4", 1'b1, 32'd8, 32'd4, 32'd2, 32'd0);

        // Reset in the middle of WAIT, then a fresh divide.
        start_op("rst_mid", 1'b1, 32'd50, 32'd6);
        repeat (19) @(negedge div_clk);
        resetn = 1'b0;
        @(negedge div_clk);
        check("midrst_busy", busy, 0);
        check("midrst_div", div, 0);
        check("midrst_div_signed", div_signed, 0);
        check("midrst_x", x, 0);
        check("midrst_y", y, 0);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        resetn = 1'b1;
        m_lo = 32'd0; m_hi = 32'd0;
        run_op("div_15_4", 1'b1, 32'd15, 32'd4, 32'd3, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 div_clk  input  1  clock; all state updates on rising edge.
REQ-002 resetn  input  1  reset, synchronous, active-low.
REQ-003 req_valid  input  1  pipeline requests a divide.
REQ-004 req_signed  input  1  1 = DIV, 0 = DIVU.
REQ-005 req_a / req_b  input  32 each  dividend / divisor.
REQ-006 req_ready  output  1  high only in IDLE; a request is accepted when req_valid & req_ready.
REQ-007 busy  output  1  registered; high in every state except IDLE, used as the pipeline stall.
REQ-008 flush  input  1  pipeline cancel (active only with DIV_FLUSH_EN).
REQ-009 mthi_we / mtlo_we  input  1 each; wdata  input  32  direct HI/LO writes.
REQ-010 hi / lo  output  32  architectural HI/LO registers.
REQ-011 div  output  1  start strobe to the divider.
REQ-012 div_signed  output  1  signedness to the divider.
REQ-013 x / y  output  32  operands to the divider.
REQ-014 s / r  input  32  divider quotient / remainder, valid only while complete.
REQ-015 complete  input  1  divider done, a single-cycle pulse.

Function
REQ-016 The FSM SHALL have states IDLE, LAUNCH, WAIT, RECOVER and DISCARD.
REQ-017 IDLE: on accept, latch req_a/req_b/req_signed into op registers and go to LAUNCH.
REQ-018 LAUNCH: div SHALL be 1 for exactly this cycle, with x/y/div_signed driven from the op registers; next state is WAIT.
REQ-019 div SHALL be 0 in every state other than LAUNCH.
REQ-020 x/y/div_signed SHALL hold stable from LAUNCH until the next accept.
REQ-021 WAIT: on complete, write LO<=s and HI<=r in the same edge, then go to RECOVER.
REQ-022 complete arrives 34 cycles after the LAUNCH edge; the controller SHALL NOT depend on that count and waits for complete only.
REQ-023 RECOVER: single cycle, then IDLE; this guarantees the divider counter has cleared before the next div strobe.
REQ-024 Accept-to-HI/LO-update latency SHALL be 36 cycles; accept-to-next-accept SHALL be a minimum of 37 cycles.
REQ-025 mthi_we/mtlo_we SHALL update HI/LO in any state.
REQ-026 If an mthi/mtlo write and a result capture fall on the same edge, the result capture wins.
REQ-027 Divisor 0: pass the divider output through unchanged; no trap or flag.
REQ-028 req_valid while busy: ignore it; the pipeline holds the request.

Reset
REQ-029 resetn low SHALL force state IDLE and set busy=0, div=0, div_signed=0, x=0, y=0, hi=0, lo=0, and op registers=0.
REQ-030 The divider shares resetn, so a reset mid-operation aborts both blocks.
REQ-031 The first accept after reset deassertion SHALL be honoured in the following cycle.

Configuration
REQ-032 The macro is DIV_FLUSH_EN.
REQ-033 When defined: flush in LAUNCH or WAIT moves to DISCARD (the LAUNCH strobe is still issued). DISCARD waits for complete without writing HI/LO, then goes to RECOVER.
REQ-034 When defined: flush in IDLE, RECOVER or DISCARD has no effect.
REQ-035 When undefined: the flush input is ignored and the DISCARD state is never entered.

Structure
REQ-036 Shared package div_pkg SHALL hold the FSM state encoding and the constant DIV_LATENCY=34, for bench use.
REQ-037 The natural sub-module is divider, the existing 32-bit iterative divider. It SHALL be instantiated by a cpu-level wrapper, not inside div_ctrl, so that div_ctrl stays testable against a behavioural divider model.

Verification
REQ-038 DIV 7/2: LO=3, HI=1 at 36 cycles after accept; busy falls the cycle after.
REQ-039 DIV -7/2 (0xFFFFFFF9, 2): LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU of the same operands: LO=0x7FFFFFFC, HI=1.
REQ-040 Back-to-back: req_valid held continuously for 100/7 then 9/3. The second accept occurs no earlier than 37 cycles after the first, div pulses exactly twice, and final LO=3, HI=0.
REQ-041 DIV_FLUSH_EN: flush 10 cycles after accepting 50/5 with prior HI=0xAA, LO=0xBB. HI/LO remain 0xAA/0xBB, busy drops after complete+1, and a following 8/4 gives LO=2.
REQ-042 Reset mid-WAIT (cycle 20): all outputs are 0 next cycle and a new 15/4 completes with LO=3, HI=3.
REQ-043 mtlo_we with wdata=0x1234 in IDLE: lo=0x1234 next cycle. mtlo_we coinciding with result capture: lo equals the quotient.
